servo_axis_sched: RTL and testbench
===================================

SERVO_AXIS_SCHED -- requirements
Module: servo_axis_sched

Interface
REQ-001 SHALL have parameter X_CENTER, 160: pan image centre, in pixels.
REQ-002 SHALL have parameter Y_CENTER, 120: tilt image centre, in pixels.
REQ-003 SHALL have parameter DEADBAND, 24: a |error| at or below this value holds the threshold.
REQ-004 SHALL have parameters PWM_MIN 500, PWM_MAX 2500 and PWM_INIT 1500: clamp limits and reset threshold, in us.
REQ-005 SHALL have port clk, input, 1: the single clock; one clock; reset is synchronous and active-low.
REQ-006 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-007 SHALL have port vsync, input, 1: frame strobe, synchronous to clk.
REQ-008 SHALL have ports x_pos and y_pos, input, 12 each: ball centroid.
REQ-009 SHALL have port pos_valid, input, 1: centroid valid for this frame.
REQ-010 SHALL have ports meas_a and meas_b, input, 16 each: measured pan and tilt servo position (ADC code).
REQ-011 SHALL have ports pwm_thres_x and pwm_thres_y, output, 15 each: servo pulse-width commands.
REQ-012 SHALL have ports upd_x and upd_y, output, 1 each: one-cycle pulse when the matching threshold is rewritten.
REQ-013 SHALL have port busy, output, 1: high while the sequence is in progress.
REQ-014 SHALL have port overrun_cnt, output, 8: saturating count of vsync edges dropped while busy.

Function
REQ-015 SHALL implement a shared datapath with one 12x12 multiplier, time-multiplexed between the pan and tilt axes.
REQ-016 SHALL use FSM states IDLE, MUL_X, UPD_X, MUL_Y and UPD_Y.
- The FSM SHALL move from IDLE to MUL_X on a vsync rising edge (vsync=1, vsync_q=0) when pos_valid=1.
- It SHALL then step through UPD_X, MUL_Y and UPD_Y, one cycle each, and return to IDLE.
REQ-017 SHALL latch x_pos, y_pos, meas_a and meas_b on the trigger edge (t0); inputs that change afterwards SHALL NOT affect the frame.
REQ-018 SHALL leave the FSM in IDLE with no updates when a vsync rising edge arrives with pos_valid=0.
REQ-019 SHALL compute base = ((meas[15:4]*2380)>>12)+240 and register it in MUL_*.
REQ-020 SHALL compute err = |pos-CENTER|, saturate it to 160, and compute step = (err*90)>>5 with truncation.
REQ-021 SHALL, in UPD_*, write new = base+step when pos<CENTER, and new = base-step when pos>=CENTER.
- All arithmetic SHALL be 16-bit signed.
- The result SHALL be clamped to [PWM_MIN, PWM_MAX].
REQ-022 SHALL hold the threshold with no upd pulse when err<=DEADBAND, pos==0 or pos>=2*CENTER.
REQ-023 SHALL meet this latency: pwm_thres_x and upd_x valid at t0+2 and pwm_thres_y and upd_y valid at t0+4; busy SHALL be high from t0+1 through t0+4.
REQ-024 SHALL ignore vsync rising edges while busy and increment overrun_cnt, saturating at 255.
REQ-025 SHALL keep each threshold unchanged between its own updates.

Reset
REQ-026 SHALL, with rst_n=0 at a clock edge, force: state IDLE, both thresholds PWM_INIT, upd_x/upd_y/busy 0, overrun_cnt 0.
REQ-027 SHALL reset vsync_q to 1, so that vsync already high when reset is released does not trigger a sequence.
REQ-028 SHALL abort any in-progress sequence when reset is asserted mid-sequence, with no partial update.

Configuration
REQ-029 SHALL compile the tilt axis in when macro SERVO_TILT_AXIS_EN is defined, giving full X+Y sequencing.
REQ-030 SHALL, when SERVO_TILT_AXIS_EN is undefined:
- remove MUL_Y and UPD_Y, with UPD_X returning to IDLE and busy high at t0+1..t0+2 only;
- tie pwm_thres_y to PWM_INIT and tie upd_y to 0.

Verification
REQ-031 SHALL cover: meas_a=0x8000, x_pos=60, pos_valid=1, vsync edge -> pwm_thres_x=1711 and upd_x at t0+2.
REQ-032 SHALL cover: meas_a=0x8000, x_pos=260 -> pwm_thres_x=1149; meas_a=0x8000, x_pos=150 -> hold at 1500, no upd_x.
REQ-033 SHALL cover: x_pos=136 (err=24) -> hold; x_pos=135 (err=25) -> step 70, pwm_thres_x=1500 from 1430+70.
REQ-034 SHALL cover: meas_a=0xFFF0, x_pos=10 -> 2619+421 clamped to 2500; meas_a=0x0000, x_pos=310 -> 240-421 clamped to 500.
REQ-035 SHALL cover: meas_b=0x8000, y_pos=20 with the macro defined -> pwm_thres_y=1711 at t0+4; with the macro undefined -> 1500 and no upd_y.
REQ-036 SHALL cover:
- a second vsync edge at t0+2 -> overrun_cnt=1;
- rst_n low at t0+1 -> outputs at PWM_INIT and no upd pulses.

Source files
------------

// File: rtl/servo_axis_sched.sv
// rtl/servo_axis_sched.sv - Frame-paced pan/tilt servo threshold scheduler, one shared base multiplier.
// Tilt axis sequencing is compiled in only when SERVO_TILT_AXIS_EN is defined.
module servo_axis_sched #(
    parameter int X_CENTER = 160,
    parameter int Y_CENTER = 120,
    parameter int DEADBAND = 24,
    parameter int PWM_MIN  = 500,
    parameter int PWM_MAX  = 2500,
    parameter int PWM_INIT = 1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    input  logic        pos_valid,
    input  logic [15:0] meas_a,
    input  logic [15:0] meas_b,
    output logic [14:0] pwm_thres_x,
    output logic [14:0] pwm_thres_y,
    output logic        upd_x,
    output logic        upd_y,
    output logic        busy,
    output logic [7:0]  overrun_cnt
);

`ifdef SERVO_TILT_AXIS_EN
    typedef enum logic [2:0] {IDLE, MUL_X, UPD_X, MUL_Y, UPD_Y} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL_X, UPD_X} state_t;
`endif

    localparam logic signed [15:0] XC      = 16'(X_CENTER);
    localparam logic signed [15:0] YC      = 16'(Y_CENTER);
    localparam logic signed [15:0] DB      = 16'(DEADBAND);
    localparam logic signed [15:0] P_MIN   = 16'(PWM_MIN);
    localparam logic signed [15:0] P_MAX   = 16'(PWM_MAX);
    localparam logic [14:0]        P_INIT  = 15'(PWM_INIT);
    localparam logic signed [15:0] ERR_SAT = 16'sd160;

    state_t             state_q, state_d;
    logic               vsync_q, vsync_d;
    logic [11:0]        xp_q, xp_d, ma_q, ma_d;
    logic signed [15:0] base_q, base_d, step_q, step_d;
    logic               add_q, add_d, hold_q, hold_d;
    logic [14:0]        thx_q, thx_d;
    logic               updx_q, updx_d;
    logic               busy_q, busy_d;
    logic [7:0]         ovr_q, ovr_d;
`ifdef SERVO_TILT_AXIS_EN
    logic [11:0]        yp_q, yp_d, mb_q, mb_d;
    logic [14:0]        thy_q, thy_d;
    logic               updy_q, updy_d;
`endif

    logic [11:0]        pos_m, meas_m;
    logic signed [15:0] ctr_m, pos_s, err, err_c, step_w, base_w, sum, clamped;
    logic [23:0]        prod;
    logic               hold_w, add_w, rise, in_seq;

    // Axis operand mux in front of the single shared multiplier
    always_comb begin
`ifdef SERVO_TILT_AXIS_EN
        if (state_q == MUL_Y) begin
            pos_m  = yp_q;
            meas_m = mb_q;
            ctr_m  = YC;
        end else begin
            pos_m  = xp_q;
            meas_m = ma_q;
            ctr_m  = XC;
        end
`else
        pos_m  = xp_q;
        meas_m = ma_q;
        ctr_m  = XC;
`endif
        pos_s   = signed'({4'b0, pos_m});
        err     = (pos_s >= ctr_m) ? (pos_s - ctr_m) : (ctr_m - pos_s);
        err_c   = (err > ERR_SAT) ? ERR_SAT : err;
        step_w  = ((err_c <<< 6) + (err_c <<< 4) + (err_c <<< 3) + (err_c <<< 1)) >>> 5;
        prod    = {12'b0, meas_m} * 24'd2380;
        base_w  = signed'({4'b0, prod[23:12]}) + 16'sd240;
        hold_w  = (err <= DB) || (pos_m == 12'd0) || (pos_s >= (ctr_m <<< 1));
        add_w   = (pos_s < ctr_m);
        sum     = add_q ? (base_q + step_q) : (base_q - step_q);
        clamped = (sum < P_MIN) ? P_MIN : ((sum > P_MAX) ? P_MAX : sum);
    end

    always_comb begin
        state_d = state_q;
        vsync_d = vsync;
        xp_d    = xp_q;
        ma_d    = ma_q;
        base_d  = base_q;
        step_d  = step_q;
        add_d   = add_q;
        hold_d  = hold_q;
        thx_d   = thx_q;
        updx_d  = 1'b0;
        busy_d  = (state_q != IDLE);
        ovr_d   = ovr_q;
`ifdef SERVO_TILT_AXIS_EN
        yp_d    = yp_q;
        mb_d    = mb_q;
        thy_d   = thy_q;
        updy_d  = 1'b0;
`endif
        rise   = vsync & ~vsync_q;
        in_seq = (state_q != IDLE) | busy_q;
        if (rise && in_seq && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
        case (state_q)
            IDLE: begin
                if (rise && !in_seq && pos_valid) begin
                    xp_d    = x_pos;
                    ma_d    = meas_a[15:4];
`ifdef SERVO_TILT_AXIS_EN
                    yp_d    = y_pos;
                    mb_d    = meas_b[15:4];
`endif
                    state_d = MUL_X;
                end
            end
            MUL_X: begin
                base_d  = base_w;
                step_d  = step_w;
                add_d   = add_w;
                hold_d  = hold_w;
                state_d = UPD_X;
            end
            UPD_X: begin
                if (!hold_q) begin
                    thx_d  = clamped[14:0];
                    updx_d = 1'b1;
                end
`ifdef SERVO_TILT_AXIS_EN
                state_d = MUL_Y;
`else
                state_d = IDLE;
`endif
            end
`ifdef SERVO_TILT_AXIS_EN
            MUL_Y: begin
                base_d  = base_w;
                step_d  = step_w;
                add_d   = add_w;
                hold_d  = hold_w;
                state_d = UPD_Y;
            end
            UPD_Y: begin
                if (!hold_q) begin
                    thy_d  = clamped[14:0];
                    updy_d = 1'b1;
                end
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // vsync_q resets high so a strobe already high at reset release is not an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vsync_q <= 1'b1;
            xp_q    <= '0;
            ma_q    <= '0;
            base_q  <= '0;
            step_q  <= '0;
            add_q   <= 1'b0;
            hold_q  <= 1'b1;
            thx_q   <= P_INIT;
            updx_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= '0;
`ifdef SERVO_TILT_AXIS_EN
            yp_q    <= '0;
            mb_q    <= '0;
            thy_q   <= P_INIT;
            updy_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vsync_q <= vsync_d;
            xp_q    <= xp_d;
            ma_q    <= ma_d;
            base_q  <= base_d;
            step_q  <= step_d;
            add_q   <= add_d;
            hold_q  <= hold_d;
            thx_q   <= thx_d;
            updx_q  <= updx_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
`ifdef SERVO_TILT_AXIS_EN
            yp_q    <= yp_d;
            mb_q    <= mb_d;
            thy_q   <= thy_d;
            updy_q  <= updy_d;
`endif
        end
    end

    assign pwm_thres_x = thx_q;
    assign upd_x       = updx_q;
    assign busy        = busy_q;
    assign overrun_cnt = ovr_q;

`ifdef SERVO_TILT_AXIS_EN
    assign pwm_thres_y = thy_q;
    assign upd_y       = updy_q;
    logic unused_ok;
    assign unused_ok = ^{prod[11:0], clamped[15], meas_a[3:0], meas_b[3:0]};
`else
    assign pwm_thres_y = P_INIT;
    assign upd_y       = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{prod[11:0], clamped[15], meas_a[3:0], meas_b, y_pos};
`endif

endmodule

// File: tb/tb_servo_axis_sched.sv
// tb/tb_servo_axis_sched.sv - Scoreboard bench for servo_axis_sched (either SERVO_TILT_AXIS_EN build).
module tb_servo_axis_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        pos_valid = 1'b0;
    logic [11:0] x_pos = '0;
    logic [11:0] y_pos = '0;
    logic [15:0] meas_a = '0;
    logic [15:0] meas_b = '0;
    logic [14:0] pwm_thres_x, pwm_thres_y;
    logic        upd_x, upd_y, busy;
    logic [7:0]  overrun_cnt;

`ifdef SERVO_TILT_AXIS_EN
    localparam bit TILT = 1'b1;
    localparam int BLEN = 4;
`else
    localparam bit TILT = 1'b0;
    localparam int BLEN = 2;
`endif

    servo_axis_sched dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .x_pos(x_pos), .y_pos(y_pos),
        .pos_valid(pos_valid), .meas_a(meas_a), .meas_b(meas_b),
        .pwm_thres_x(pwm_thres_x), .pwm_thres_y(pwm_thres_y),
        .upd_x(upd_x), .upd_y(upd_y), .busy(busy), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t qx[$];
    exp_t qy[$];
    int n_tests = 0;
    int n_fail  = 0;
    int exp_x   = 1500;
    int exp_y   = 1500;
    int exp_ovr = 0;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (upd_x) begin
            if (qx.size() == 0) check("upd_x unexpected", 1, 0);
            else begin
                e = qx.pop_front();
                check("pwm_thres_x on upd", int'(pwm_thres_x), e.val);
                check("upd_x cycle", cyc, e.cyc);
            end
        end
        if (upd_y) begin
            if (qy.size() == 0) check("upd_y unexpected", 1, 0);
            else begin
                e = qy.pop_front();
                check("pwm_thres_y on upd", int'(pwm_thres_y), e.val);
                check("upd_y cycle", cyc, e.cyc);
            end
        end
    end

    // mode 0 normal, 1 extra vsync at t0+2, 2 reset at t0+1, 3 pos_valid low; vx/vy < 0 means hold
    task automatic frame(input int xp, input int yp, input int ma, input int mb,
                         input int vx, input int vy, input int mode);
        int t0;
        int exp_b;
        @(negedge clk);
        x_pos     = 12'(xp);
        y_pos     = 12'(yp);
        meas_a    = 16'(ma);
        meas_b    = 16'(mb);
        pos_valid = (mode != 3);
        vsync     = 1'b1;
        t0        = cyc + 1;
        if (mode < 2) begin
            if (vx >= 0) begin
                qx.push_back('{vx, t0 + 2});
                exp_x = vx;
            end
            if (TILT && vy >= 0) begin
                qy.push_back('{vy, t0 + 4});
                exp_y = vy;
            end
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                x_pos     = 12'd5;
                y_pos     = 12'd5;
                meas_a    = 16'hFFFF;
                meas_b    = 16'hFFFF;
                pos_valid = 1'b0;
                vsync     = 1'b0;
                if (mode == 2) rst_n = 1'b0;
            end
            if (mode == 1 && k == 1) begin
                vsync     = 1'b1;
                pos_valid = 1'b1;
            end
            if (mode == 1 && k == 2) begin
                vsync     = 1'b0;
                pos_valid = 1'b0;
            end
            if (mode == 2 && k == 2) rst_n = 1'b1;
            exp_b = (mode < 2 && k >= 1 && k <= BLEN) ? 1 : 0;
            check("busy", int'(busy), exp_b);
        end
        if (mode == 2) begin
            exp_x   = 1500;
            exp_y   = 1500;
            exp_ovr = 0;
        end
        if (mode == 1 && exp_ovr < 255) exp_ovr++;
        check("pwm_thres_x held", int'(pwm_thres_x), exp_x);
        check("pwm_thres_y held", int'(pwm_thres_y), exp_y);
        check("overrun_cnt", int'(overrun_cnt), exp_ovr);
    endtask

    initial begin
        rst_n     = 1'b0;
        vsync     = 1'b1;
        pos_valid = 1'b1;
        x_pos     = 12'd60;
        meas_a    = 16'h8000;
        repeat (3) @(negedge clk);
        check("reset pwm_thres_x", int'(pwm_thres_x), 1500);
        check("reset pwm_thres_y", int'(pwm_thres_y), 1500);
        check("reset upd_x", int'(upd_x), 0);
        check("reset upd_y", int'(upd_y), 0);
        check("reset busy", int'(busy), 0);
        check("reset overrun_cnt", int'(overrun_cnt), 0);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("busy after release with vsync high", int'(busy), 0);
        end
        vsync     = 1'b0;
        pos_valid = 1'b0;
        @(negedge clk);

        //     x    y    meas_a   meas_b   exp_x exp_y mode
        frame(150, 120, 'h8000, 'h8000,    -1,   -1,   0);
        frame(136, 120, 'h8000, 'h8000,    -1,   -1,   0);
        frame( 60,  20, 'h8000, 'h8000,  1711, 1711,   0);
        frame(260, 120, 'h8000, 'h8000,  1149,   -1,   0);
        frame(135,   0, 'h8000, 'h8000,  1500,   -1,   0);
        frame( 10, 240, 'hFFF0, 'h8000,  2500,   -1,   0);
        frame(310, 220, 'h0000, 'h0000,   500,  500,   0);
        frame(320, 119, 'h8000, 'h8000,    -1,   -1,   0);
        frame(  0, 120, 'h8000, 'h8000,    -1,   -1,   0);
        frame( 60,  20, 'h8000, 'h8000,  1711, 1711,   1);
        frame(260, 120, 'h8000, 'h8000,    -1,   -1,   3);
        frame(260,  20, 'h8000, 'h8000,    -1,   -1,   2);
        frame(260,  20, 'h8000, 'h8000,  1149, 1711,   0);

        repeat (4) @(negedge clk);
        check("x scoreboard drained", qx.size(), 0);
        check("y scoreboard drained", qy.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
